// File: rtl/ff_wnd_iter.sv
// Window iterator: walks a loaded bitmap from the least-significant set bit upward,
// emitting base + offset for each set bit over a valid/ready handshake.
module ff_wnd_iter #(
  parameter int WND_WIDTH     = 64,
  parameter int WND_IND_WIDTH = $clog2(WND_WIDTH),
  parameter int BASE_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_val,
  output logic                  load_rdy,
  input  logic [WND_WIDTH-1:0]  load_bitmap,
  input  logic [BASE_WIDTH-1:0] load_base,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [BASE_WIDTH-1:0] out_ind,
  output logic                  out_last,
  output logic                  done,
  input  logic                  flush,
  output logic                  busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [WND_WIDTH-1:0]    rem_r;
  logic [BASE_WIDTH-1:0]   base_r;

  logic [WND_WIDTH-1:0]     src_bits_s;
  logic [BASE_WIDTH-1:0]    src_base_s;
  logic [WND_IND_WIDTH-1:0] ff_s;
  logic [WND_WIDTH-1:0]     next_rem_s;
  logic [BASE_WIDTH-1:0]    next_ind_s;
  logic                     hs_s;

  // Lowest set bit wins, matching the upstream find-first tree.
  function automatic logic [WND_IND_WIDTH-1:0] find_first(input logic [WND_WIDTH-1:0] bits);
    logic [WND_IND_WIDTH-1:0] idx;
    idx = '0;
    for (int i = WND_WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = WND_IND_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Select the bitmap/base being searched: the incoming load in IDLE, the residue in RUN.
  always_comb begin
    src_bits_s = rem_r;
    src_base_s = base_r;
    if (state_r == IDLE) begin
      src_bits_s = load_bitmap;
      src_base_s = load_base;
    end else begin
      src_bits_s = rem_r;
      src_base_s = base_r;
    end
    ff_s       = find_first(src_bits_s);
    next_rem_s = src_bits_s & (src_bits_s - WND_WIDTH'(1));
    next_ind_s = src_base_s + BASE_WIDTH'(ff_s);
    hs_s       = out_val & out_rdy;
  end

  assign load_rdy = (state_r == IDLE);
  assign busy     = (state_r == RUN);

  // Iterator state and registered outputs; flush overrides load and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rem_r    <= '0;
      base_r   <= '0;
      out_val  <= 1'b0;
      out_ind  <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else if (flush) begin
      state_r  <= IDLE;
      rem_r    <= '0;
      out_val  <= 1'b0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_val) begin
            if (|load_bitmap) begin
              state_r  <= RUN;
              base_r   <= load_base;
              rem_r    <= next_rem_s;
              out_val  <= 1'b1;
              out_ind  <= next_ind_s;
              out_last <= (next_rem_s == '0);
            end else begin
              done <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (hs_s) begin
            if (out_last) begin
              state_r  <= IDLE;
              out_val  <= 1'b0;
              out_last <= 1'b0;
              done     <= 1'b1;
            end else begin
              rem_r    <= next_rem_s;
              out_ind  <= next_ind_s;
              out_last <= (next_rem_s == '0);
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r  <= IDLE;
          rem_r    <= '0;
          out_val  <= 1'b0;
          out_last <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ff_wnd_iter.md
Name: ff_wnd_iter

Overview:
Sequential iterator placed directly downstream of the find-first tree in the bitmap-ops path. It accepts a window bitmap plus window base sequence number, then emits the absolute index of every set bit in ascending order, one per valid/ready handshake. Each emitted bit is cleared internally. The find-first selection uses the same least-significant-set-bit priority as the tree. When the window is exhausted, the block returns to idle and pulses done.

Parameters:
WND_WIDTH, 64, bitmap width in bits; must be a power of 2, minimum 2
WND_IND_WIDTH, clogb2(WND_WIDTH), width of the in-window offset
BASE_WIDTH, 32, width of the base and of the absolute output index

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
load_val  in  1  load request
load_rdy  out  1  load accepted when load_val & load_rdy
load_bitmap  in  WND_WIDTH  window bitmap; bit i = offset i
load_base  in  BASE_WIDTH  absolute sequence number of bit 0
out_val  out  1  out_ind valid
out_rdy  in  1  consumer ready
out_ind  out  BASE_WIDTH  absolute index = base + offset of the current set bit
out_last  out  1  current out_ind is the final set bit of the window
done  out  1  one-cycle pulse when the window is exhausted
flush  in  1  synchronous abort of the current window
busy  out  1  high when state is RUN

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_val=0; out_ind=0; out_last=0; done=0; busy=0; remaining bitmap=0; base register=0. load_rdy=1 after reset.
- State machine:
  - IDLE: load_rdy=1. On accept with load_bitmap != 0:
    - ff = offset of the least-significant set bit.
    - Next cycle: out_val=1; out_ind=load_base+ff; remaining=load_bitmap with bit ff cleared; out_last=(remaining==0); state=RUN.
  - IDLE, accept with load_bitmap == 0: no output is produced; done=1 for the next cycle; state stays IDLE.
  - RUN: load_rdy=0; out_val, out_ind and out_last are held stable while out_rdy=0.
  - RUN, handshake (out_val & out_rdy) with out_last=0: in the next cycle out_ind=base+ff(remaining), that bit is cleared from remaining, and out_last is recomputed. Zero bubbles, so one index is emitted per cycle under continuous out_rdy.
  - RUN, handshake with out_last=1: next cycle out_val=0, out_last=0, done=1 (single cycle), state=IDLE.
- Latency: load accept to first out_val = 1 cycle. Last handshake to load_rdy=1 = 1 cycle, so back-to-back windows have a minimum 1-cycle gap.
- Registered outputs: out_val, out_ind, out_last and done. load_rdy and busy are decoded directly from state.
- Arithmetic:
  - out_ind = (base + zero-extended offset) mod 2^BASE_WIDTH; wrap-around is silent.
  - The base is captured at load and does not change during RUN.
- flush:
  - Any state: next cycle state=IDLE, out_val=0, out_last=0, remaining=0, done=0.
  - flush takes priority over a simultaneous handshake or load, so a load presented together with flush is not accepted.
  - A handshake in the same cycle as flush still counts as consumed by the consumer. No further index is produced.
- load_val in RUN is ignored (load_rdy=0); the bitmap and base are not sampled.
- Reset mid-window: immediate return to the reset values. No done pulse is generated.

Test Plan:
- Load bitmap=64'h0000_0000_0000_0092, base=100, out_rdy=1 -> out_ind 101,104,107 on 3 consecutive cycles; out_last only with 107; done 1 cycle later; load_rdy=1 the same cycle as done.
- Same load, out_rdy toggled 1,0,0,1,1 -> out_ind holds 104 while out_rdy=0; sequence 101,104,107 with no loss or duplication.
- Load bitmap=0, base=5 -> out_val never rises; done pulses 1 cycle after accept; state stays IDLE.
- Load bitmap=64'h8000_0000_0000_0001, base=32'hFFFF_FFF0 -> out_ind 32'hFFFF_FFF0 then 32'h0000_002F (wrap); out_last on the second.
- Load 64'hFFFF_FFFF_FFFF_FFFF, base=0; flush asserted after 10 handshakes, with load_val held high -> out_val=0 next cycle, no done, load not accepted in the flush cycle; a new load of 64'h4, base 0, then yields the single output 2 with out_last=1.
- Assert rst_n=0 mid-window with out_val=1 -> all outputs 0 asynchronously; after release load_rdy=1 and remaining is empty (a later load of 64'h1 yields only the base index).
